// File: rtl/rfphoenix_thread_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rfPhoenixPkg
//  Description : Shared thread-id / order-tag types and the per-thread
//                scheduler state record used by the rfPhoenix thread scheduler.
//  Revision    : 1.0  initial release
// ============================================================================
package rfPhoenixPkg;

    localparam int NTHREADS = 4;
    localparam int TidMSB   = $clog2(NTHREADS) - 1;

    typedef logic [TidMSB:0] Tid;
    typedef logic [11:0]     order_tag_t;

    // Per-thread scheduler state: sleep flag, I$-miss backoff, in-flight count
    typedef struct packed {
        logic       sleep;
        logic [4:0] imiss_cnt;
        logic [3:0] inflight;
    } sched_state_t;

    localparam order_tag_t SCHED_TAG_RST = 12'h000;

endpackage
`default_nettype wire

// File: rtl/rfphoenix_thread_sched_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rfphoenix_rr_pick
//  Description : Rotating-priority picker. Returns the first asserted request
//                scanning upward from last+1 with wrap-around.
//  Revision    : 1.0  initial release
// ============================================================================
module rfphoenix_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last,
    output logic [IDX_W-1:0] o_winner,
    output logic             o_found
);

    logic [IDX_W-1:0] w_idx;

    // Scan candidates last+1 .. last+N_REQ (mod N_REQ); first hit wins
    always_comb begin
        o_winner = '0;
        o_found  = 1'b0;
        w_idx    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = IDX_W'((int'(i_last) + i) % N_REQ);
            if (!o_found && i_req[w_idx]) begin
                o_found  = 1'b1;
                o_winner = w_idx;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rfphoenix_thread_sched.sv
`default_nettype none
// ============================================================================
//  Module      : rfphoenix_thread_sched
//  Description : Per-cycle round-robin thread issue scheduler. Skips threads
//                that are asleep, in I$-miss backoff or at their in-flight
//                limit, and stamps every issued slot with a 12-bit order tag.
//                Optional: RFPHOENIX_THREAD_PRIO_EN adds a 2-bit per-thread
//                priority input; highest priority wins, RR among equals.
//  Revision    : 1.0  initial release
// ============================================================================
module rfphoenix_thread_sched
    import rfPhoenixPkg::*;
#(
    parameter int                  MAX_INFLIGHT  = 4,
    parameter logic [4:0]          IMISS_BACKOFF = 5'd16,
    parameter logic [NTHREADS-1:0] RST_AWAKE     = NTHREADS'(1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NTHREADS-1:0]   sleep_set_i,
    input  logic [NTHREADS-1:0]   sleep_clr_i,
    input  logic                  imiss_i,
    input  logic [TidMSB:0]       imiss_tid_i,
    input  logic [NTHREADS-1:0]   imiss_clr_i,
    input  logic                  retire_i,
    input  logic [TidMSB:0]       retire_tid_i,
    input  logic                  flush_i,
    input  logic [TidMSB:0]       flush_tid_i,
    input  logic                  stall_i,
`ifdef RFPHOENIX_THREAD_PRIO_EN
    input  logic [NTHREADS*2-1:0] prio_i,
`endif
    output logic                  issue_v_o,
    output logic [TidMSB:0]       issue_tid_o,
    output logic [11:0]           issue_tag_o,
    output logic [NTHREADS-1:0]   eligible_o,
    output logic                  idle_o
);

    localparam logic [3:0] c_max_inflight = 4'(MAX_INFLIGHT);

    sched_state_t        r_st [NTHREADS];
    Tid                  r_last;
    logic                r_issue_v;
    Tid                  r_issue_tid;
    order_tag_t          r_issue_tag;
    order_tag_t          r_next_tag;

    logic [NTHREADS-1:0] w_elig;
    logic [NTHREADS-1:0] w_req;
    logic [NTHREADS-1:0] w_sel;
    logic [NTHREADS-1:0] w_ret;
    logic [NTHREADS-1:0] w_flush;
    logic [NTHREADS-1:0] w_miss;
    Tid                  w_winner;
    logic                w_found;
    logic                w_load;

    // New slot may be registered whenever the output is empty or being consumed
    assign w_load = !r_issue_v || !stall_i;

    generate
        for (genvar t = 0; t < NTHREADS; t++) begin : g_thread
            assign w_flush[t] = flush_i  && (flush_tid_i  == Tid'(t));
            assign w_ret[t]   = retire_i && (retire_tid_i == Tid'(t));
            assign w_miss[t]  = imiss_i  && (imiss_tid_i  == Tid'(t));
            assign w_sel[t]   = w_load && w_found && (w_winner == Tid'(t));
            // The thread being flushed this cycle must not win a new slot
            assign w_elig[t]  = !r_st[t].sleep
                              && (r_st[t].imiss_cnt == 5'd0)
                              && (r_st[t].inflight < c_max_inflight)
                              && !w_flush[t];
        end
    endgenerate

`ifdef RFPHOENIX_THREAD_PRIO_EN
    logic [1:0] w_top_prio;

    // Keep only eligible threads at the highest priority level present
    always_comb begin
        w_top_prio = 2'd0;
        w_req      = '0;
        for (int t = 0; t < NTHREADS; t++) begin
            if (w_elig[t] && (prio_i[2*t +: 2] > w_top_prio)) begin
                w_top_prio = prio_i[2*t +: 2];
            end
        end
        for (int t = 0; t < NTHREADS; t++) begin
            w_req[t] = w_elig[t] && (prio_i[2*t +: 2] == w_top_prio);
        end
    end
`else
    assign w_req = w_elig;
`endif

    rfphoenix_rr_pick #(
        .N_REQ (NTHREADS),
        .IDX_W (TidMSB + 1)
    ) u_pick (
        .i_req    (w_req),
        .i_last   (r_last),
        .o_winner (w_winner),
        .o_found  (w_found)
    );

    // Per-thread sleep, I$-miss backoff and in-flight bookkeeping
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int t = 0; t < NTHREADS; t++) begin
                r_st[t].sleep     <= ~RST_AWAKE[t];
                r_st[t].imiss_cnt <= 5'd0;
                r_st[t].inflight  <= 4'd0;
            end
        end else begin
            for (int t = 0; t < NTHREADS; t++) begin
                // Set dominates clear when both arrive together
                if (sleep_set_i[t]) begin
                    r_st[t].sleep <= 1'b1;
                end else if (sleep_clr_i[t]) begin
                    r_st[t].sleep <= 1'b0;
                end

                // A fresh miss restarts backoff even if a fill clear arrives
                if (w_miss[t]) begin
                    r_st[t].imiss_cnt <= IMISS_BACKOFF;
                end else if (imiss_clr_i[t]) begin
                    r_st[t].imiss_cnt <= 5'd0;
                end else if (r_st[t].imiss_cnt != 5'd0) begin
                    r_st[t].imiss_cnt <= r_st[t].imiss_cnt - 5'd1;
                end

                // Flush wipes the count; select and retire together cancel out
                if (w_flush[t]) begin
                    r_st[t].inflight <= 4'd0;
                end else if (w_sel[t] && !w_ret[t]) begin
                    r_st[t].inflight <= r_st[t].inflight + 4'd1;
                end else if (w_ret[t] && !w_sel[t] && (r_st[t].inflight != 4'd0)) begin
                    r_st[t].inflight <= r_st[t].inflight - 4'd1;
                end
            end
        end
    end

    // Issue slot register, RR pointer and order-tag counter
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_issue_v   <= 1'b0;
            r_issue_tid <= '0;
            r_issue_tag <= SCHED_TAG_RST;
            r_next_tag  <= SCHED_TAG_RST;
            r_last      <= Tid'(NTHREADS - 1);
        end else if (w_load) begin
            if (w_found) begin
                r_issue_v   <= 1'b1;
                r_issue_tid <= w_winner;
                r_issue_tag <= r_next_tag;
                r_next_tag  <= r_next_tag + 12'd1;
                r_last      <= w_winner;
            end else begin
                r_issue_v   <= 1'b0;
            end
        end else if (flush_i && (flush_tid_i == r_issue_tid)) begin
            // A stalled slot whose thread is flushed is dropped
            r_issue_v <= 1'b0;
        end
    end

    assign issue_v_o   = r_issue_v;
    assign issue_tid_o = r_issue_tid;
    assign issue_tag_o = r_issue_tag;
    assign eligible_o  = w_elig;
    assign idle_o      = !r_issue_v && !(|w_elig);

endmodule
`default_nettype wire
